// File: rtl/isr_sched_pkg.sv
// Shared types and widths for the isr_sched round-robin square-root scheduler.
package isr_sched_pkg;
   localparam int VALUE_W  = 64;
   localparam int RESULT_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      WAIT,
      RESP
   } state_t;
endpackage

// File: rtl/isr_rr_arb.sv
// Combinational round-robin picker: first pending requester after ptr, wrapping modulo NREQ.
module isr_rr_arb #(
   parameter int NREQ = 4,
   parameter int ID_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] ptr,
   output logic [ID_W-1:0] grant,
   output logic            any
);

   // Walk from the farthest offset down to ptr+1 so the nearest pending requester wins.
   always_comb begin
      int idx;
      logic [ID_W-1:0] cand;
      idx   = 0;
      cand  = '0;
      grant = '0;
      any   = |req;
      for (int k = NREQ; k >= 1; k--) begin
         idx  = (int'(ptr) + k) % NREQ;
         cand = ID_W'(idx);
         if (req[cand]) begin
            grant = cand;
         end
      end
   end

endmodule

// File: rtl/isr_sched.sv
// Round-robin scheduler sharing one integer-square-root unit among NREQ requesters.
// Optional last-operand cache enabled by defining ISR_SCHED_BYPASS_EN.
module isr_sched
   import isr_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int ID_W = $clog2(NREQ)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*VALUE_W-1:0]  req_value,
   output logic [NREQ-1:0]          ack,
   output logic [RESULT_W-1:0]      resp_result,
   output logic [ID_W-1:0]          resp_id,
   output logic                     busy,
   output logic                     isr_reset,
   output logic [VALUE_W-1:0]       isr_value,
   input  logic                     isr_done,
   input  logic [RESULT_W-1:0]      isr_result
);

   state_t                state;
   state_t                state_next;
   logic [ID_W-1:0]       ptr;
   logic [ID_W-1:0]       cap_id;
   logic [VALUE_W-1:0]    cap_value;
   logic [RESULT_W-1:0]   cap_result;
   logic [ID_W-1:0]       grant;
   logic                  any;
   logic [VALUE_W-1:0]    grant_value;
   logic                  hit;
   logic                  hit_q;
   logic [RESULT_W-1:0]   hit_result;

   isr_rr_arb #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
      .req   (req),
      .ptr   (ptr),
      .grant (grant),
      .any   (any)
   );

   assign grant_value = req_value[VALUE_W*int'(grant) +: VALUE_W];

`ifdef ISR_SCHED_BYPASS_EN
   logic                  last_valid;
   logic [VALUE_W-1:0]    last_value;
   logic [RESULT_W-1:0]   last_result;

   assign hit        = last_valid && (grant_value == last_value);
   assign hit_result = last_result;

   // The cache only learns from real ISR completions; hit_q marks a RESP served from it.
   always_ff @(posedge clock) begin
      if (reset) begin
         last_valid  <= 1'b0;
         last_value  <= '0;
         last_result <= '0;
         hit_q       <= 1'b0;
      end else begin
         hit_q <= (state == IDLE) && any && hit;
         if (state == WAIT && isr_done) begin
            last_valid  <= 1'b1;
            last_value  <= cap_value;
            last_result <= isr_result;
         end
      end
   end
`else
   assign hit        = 1'b0;
   assign hit_result = '0;
   assign hit_q      = 1'b0;
`endif

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (any) state_next = hit ? RESP : LOAD;
         LOAD:    state_next = WAIT;
         WAIT:    if (isr_done) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ptr moves to the winner on the edge that enters RESP, from either path.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         ptr        <= ID_W'(NREQ - 1);
         cap_id     <= '0;
         cap_value  <= '0;
         cap_result <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && any) begin
            cap_id    <= grant;
            cap_value <= grant_value;
            if (hit) begin
               cap_result <= hit_result;
               ptr        <= grant;
            end
         end
         if (state == WAIT && isr_done) begin
            cap_result <= isr_result;
            ptr        <= cap_id;
         end
      end
   end

   // The ISR is released from reset only while it is actually computing for us.
   always_comb begin
      busy        = (state != IDLE);
      isr_reset   = !((state == WAIT) || (state == RESP && !hit_q));
      isr_value   = cap_value;
      ack         = '0;
      resp_id     = '0;
      resp_result = '0;
      if (state == RESP) begin
         ack         = NREQ'(1) << cap_id;
         resp_id     = cap_id;
         resp_result = cap_result;
      end
   end

endmodule
